organ_voice_bank: RTL
=====================

# organ_voice_bank

Parametrised polyphonic square-wave voice bank for the electronic organ. It accepts note-on and note-off events from the keypad front end over a valid/ready handshake and allocates them to `VOICES` independent tone voices. Each voice has a per-voice interval mode. The bank mixes all active voices into signed 16-bit left/right samples for `speak_ctl`, and it exports voice occupancy and the last accepted note for the seven-segment path.

## Interface
Parameters:
- `VOICES`, 4: number of voices, 1..8.
- `DIV_W`, 20: divider counter width.
- `DIV_SHIFT`, 0: table dividers are right-shifted by this amount (simulation speed-up).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ev_valid` in 1: event offered.
- `ev_ready` out 1: bank can accept an event.
- `ev_on` in 1: 1 = note-on, 0 = note-off.
- `ev_note` in 4: keypad key code, 0..15.
- `ev_mode` in 1: 0 = unison, 1 = right channel one octave down. Captured per voice at note-on.
- `audio_left` out 16: signed mix, left.
- `audio_right` out 16: signed mix, right.
- `voice_active` out VOICES: per-voice busy flags.
- `last_note` out 4: note of the last accepted event.

## Operation
- **Divider lookup:** `ev_note` indexes the 16-entry `NOTE_DIV` table, then the value is shifted by `DIV_SHIFT`. Key codes 10,0..9,11..15 map to 90909, 81632, 76628, 68259, 60606, 57306, 51020, 45454, 40485, 38167, 34013, 30303, 28653, 25510, 22727, 20242.
- **Divider floor:** a shifted divider below 2 is forced to 2.
- **Left/right dividers:** left divider = D. Right divider = D if mode 0. If mode 1 it is 2·D, saturated at 2^DIV_W−1.
- **Voice tone generation:**
  - Each voice has one counter and one phase bit per channel.
  - The counter counts 0..div−1. At div−1 it wraps to 0 and the phase toggles, so the half-period is div cycles.
  - Phase 0 contributes +A, phase 1 contributes −A. An inactive voice contributes 0.
- **Amplitude:** A = 2^(15−ceil(log2 VOICES)) − 1, which is 8191 for VOICES=4. The sum of all voices can never overflow; no saturation logic is needed.
- **FSM:** states `IDLE` and `ALLOC`.
  - `IDLE`: `ev_ready`=1. On `ev_valid`&&`ev_ready`, latch on/note/mode, update `last_note`, go to `ALLOC`.
  - `ALLOC`: `ev_ready`=0. Apply the event in this cycle, then return to `IDLE`.
- **Note-on priority:**
  1. A voice already holding the same note is retriggered: counters=0, phases=0, new mode.
  2. Otherwise the lowest-index free voice is taken.
  3. Otherwise the voice at `steal_ptr` is overwritten and `steal_ptr` advances modulo VOICES.
- **Note-off:** clears every active voice holding that note. No match is a no-op. `steal_ptr` is unchanged.
- Inactive voices hold their counters at 0.

## Timing
- **Reset values:**
  - `audio_left`/`audio_right` = 0.
  - `voice_active` = 0.
  - `last_note` = 0.
  - `steal_ptr` = 0.
  - All counters and phases = 0.
  - FSM = `IDLE`.
  - `ev_ready` = 0 while `rst_n`=0, and 1 from the first edge with `rst_n`=1.
- **Throughput:** one event per 2 cycles.
- **Latency:** with the event accepted at edge N, `voice_active` updates at N+1 and the audio outputs reflect the new voice at N+2 (registered mix).
- **First sample:** a new or retriggered voice outputs +A on its first audio sample. Its first toggle appears div cycles later.
- **Reset mid-event:** `rst_n` low during `ALLOC` discards the latched event. No voice changes.
- **Held `ev_valid`:** `ev_valid` held high with a constant payload is accepted again every 2 cycles. The producer must drop it after the handshake.

## Structure
- Package `organ_pkg` holds:
  - the `NOTE_DIV` table;
  - the `MODE_UNISON`/`MODE_OCTAVE` constants;
  - the `voice_amp(VOICES)` function;
  - the FSM state typedef.
- Sub-module `organ_voice`: one voice. It owns note, mode, active, two counters and two phases, has load/retrigger/clear inputs, and outputs signed ±A/0 for left and right.
- Top-level `organ_voice_bank`: FSM, allocation, `steal_ptr`, and the registered adder tree.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0 and `ev_ready`=0. After release, `ev_ready`=1 on the next edge.
- **Single voice, unison:** `DIV_SHIFT`=10, note-on key 1, mode 0 (div 74) → `voice_active`=0001. Both audio outputs are +8191 for 74 cycles, then −8191.
- **Octave mode:** note-on key 1, mode 1 → left toggles every 74 cycles, right every 148. `last_note`=1.
- **Voice stealing:** note-on keys 0,1,2,3 → `voice_active`=1111. Key 4 replaces voice 0 and key 5 replaces voice 1. The mix is at most ±32764.
- **Note-off:** note-off key 9 (not held) → no change. Note-off key 2 → its bit clears and the mix drops by that voice's ±8191 two cycles after accept.
- **Retrigger and reset mid-event:** note-on key 3 twice → the same voice is restarted and no new voice is allocated. Assert `rst_n`=0 in `ALLOC` → that event leaves no trace.

Source files
------------

// File: rtl/organ_voice_bank_pkg.sv
// Shared constants, the note divider table, the amplitude helper and the FSM state type
// for the organ voice bank.
package organ_pkg;

    // Indexed by keypad key code; key 10 is the lowest pitch on the keypad.
    localparam logic [31:0] NOTE_DIV [16] = '{
        32'd81632, 32'd76628, 32'd68259, 32'd60606,
        32'd57306, 32'd51020, 32'd45454, 32'd40485,
        32'd38167, 32'd34013, 32'd90909, 32'd30303,
        32'd28653, 32'd25510, 32'd22727, 32'd20242
    };

    localparam logic MODE_UNISON = 1'b0;
    localparam logic MODE_OCTAVE = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ALLOC = 1'b1
    } bank_state_t;

    // Per-voice amplitude sized so the sum of every voice fits in signed 16 bits.
    function automatic int voice_amp(input int voices);
        return (1 << (15 - $clog2(voices))) - 1;
    endfunction

endpackage

// File: rtl/organ_voice_bank_if.sv
// Note event channel from the keypad front end into the voice bank.
interface organ_voice_bank_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [3:0] ev_note;
    logic       ev_mode;

    modport master (output ev_valid, output ev_on, output ev_note, output ev_mode,
                    input ev_ready);
    modport slave  (input ev_valid, input ev_on, input ev_note, input ev_mode,
                    output ev_ready);
endinterface

// File: rtl/organ_voice_bank_voice.sv
// One square-wave voice: holds note/mode/divider, runs independent left and right
// half-period counters and drives +A / -A / 0 per channel.
module organ_voice
    import organ_pkg::*;
#(
    parameter int DIV_W = 20,
    parameter int AMP   = 8191
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     retrig,
    input  logic                     clear,
    input  logic [3:0]               note_in,
    input  logic                     mode_in,
    input  logic [DIV_W-1:0]         div_in,
    output logic                     active,
    output logic [3:0]               note,
    output logic signed [15:0]       out_l,
    output logic signed [15:0]       out_r
);

    localparam logic signed [15:0] POS = 16'(AMP);
    localparam logic signed [15:0] NEG = -POS;

    logic             mode;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_l;
    logic [DIV_W-1:0] cnt_r;
    logic             ph_l;
    logic             ph_r;

    // Octave-down right channel doubles the divider, saturating if the top bit is set.
    always_comb begin
        div_r = div_d;
        if (mode == MODE_OCTAVE)
            div_r = div_d[DIV_W-1] ? '1 : {div_d[DIV_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            note   <= '0;
            mode   <= MODE_UNISON;
            div_d  <= '0;
            cnt_l  <= '0;
            cnt_r  <= '0;
            ph_l   <= 1'b0;
            ph_r   <= 1'b0;
        end else if (clear) begin
            active <= 1'b0;
            cnt_l  <= '0;
            cnt_r  <= '0;
            ph_l   <= 1'b0;
            ph_r   <= 1'b0;
        end else if (load || retrig) begin
            active <= 1'b1;
            if (load)
                note <= note_in;
            mode   <= mode_in;
            div_d  <= div_in;
            cnt_l  <= '0;
            cnt_r  <= '0;
            ph_l   <= 1'b0;
            ph_r   <= 1'b0;
        end else if (active) begin
            if (cnt_l == div_d - DIV_W'(1)) begin
                cnt_l <= '0;
                ph_l  <= ~ph_l;
            end else begin
                cnt_l <= cnt_l + DIV_W'(1);
            end
            if (cnt_r == div_r - DIV_W'(1)) begin
                cnt_r <= '0;
                ph_r  <= ~ph_r;
            end else begin
                cnt_r <= cnt_r + DIV_W'(1);
            end
        end
    end

    assign out_l = !active ? '0 : (ph_l ? NEG : POS);
    assign out_r = !active ? '0 : (ph_r ? NEG : POS);

endmodule

// File: rtl/organ_voice_bank.sv
// Polyphonic voice bank: event handshake FSM, voice allocation with round-robin
// stealing, and a registered mix of all voices into left/right samples.
//   state | meaning
//   IDLE  | ready for an event; accepted event is latched
//   ALLOC | latched event is applied to the voices
module organ_voice_bank
    import organ_pkg::*;
#(
    parameter int VOICES    = 4,
    parameter int DIV_W     = 20,
    parameter int DIV_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    organ_voice_bank_if.slave    ev,
    output logic signed [15:0]   audio_left,
    output logic signed [15:0]   audio_right,
    output logic [VOICES-1:0]    voice_active,
    output logic [3:0]           last_note
);

    localparam int               SP_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int               AMP     = voice_amp(VOICES);
    localparam logic [DIV_W-1:0] DIV_MAX = '1;

    bank_state_t       state, state_nx;
    logic              live;
    logic              accept;
    logic              on_q;
    logic              mode_q;
    logic [3:0]        note_q;
    logic [SP_W-1:0]   steal_ptr, steal_nx;
    logic [31:0]       div_base;
    logic [DIV_W-1:0]  div_d;
    logic [VOICES-1:0] v_match, v_load, v_retrig, v_clear;
    logic              hit;
    logic [3:0]        v_note [VOICES];
    logic signed [15:0] v_l [VOICES];
    logic signed [15:0] v_r [VOICES];
    logic signed [15:0] sum_l, sum_r;

    assign accept = ev.ev_valid && ev.ev_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            on_q      <= 1'b0;
            mode_q    <= MODE_UNISON;
            note_q    <= '0;
            last_note <= '0;
            steal_ptr <= '0;
        end else begin
            state     <= state_nx;
            live      <= 1'b1;
            steal_ptr <= steal_nx;
            if (accept) begin
                on_q      <= ev.ev_on;
                mode_q    <= ev.ev_mode;
                note_q    <= ev.ev_note;
                last_note <= ev.ev_note;
            end
        end
    end

    // live keeps ready low through reset and for the release edge itself.
    always_comb begin
        state_nx    = state;
        ev.ev_ready = 1'b0;
        case (state)
            IDLE: begin
                ev.ev_ready = live;
                if (ev.ev_valid && live)
                    state_nx = ALLOC;
            end
            ALLOC:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        div_base = NOTE_DIV[note_q] >> DIV_SHIFT;
        if (div_base < 32'd2)
            div_base = 32'd2;
        if (div_base > 32'(DIV_MAX))
            div_base = 32'(DIV_MAX);
        div_d = div_base[DIV_W-1:0];
    end

    // Note-on: retrigger a holder of the note, else lowest free voice, else steal.
    always_comb begin
        v_match  = '0;
        v_load   = '0;
        v_retrig = '0;
        v_clear  = '0;
        steal_nx = steal_ptr;
        hit      = 1'b0;
        for (int i = 0; i < VOICES; i++)
            v_match[i] = voice_active[i] && (v_note[i] == note_q);
        if (state == ALLOC) begin
            if (!on_q) begin
                v_clear = v_match;
            end else if (|v_match) begin
                for (int i = 0; i < VOICES; i++)
                    if (v_match[i] && !hit) begin
                        v_retrig[i] = 1'b1;
                        hit         = 1'b1;
                    end
            end else if (!(&voice_active)) begin
                for (int i = 0; i < VOICES; i++)
                    if (!voice_active[i] && !hit) begin
                        v_load[i] = 1'b1;
                        hit       = 1'b1;
                    end
            end else begin
                v_load[steal_ptr] = 1'b1;
                steal_nx = (steal_ptr == SP_W'(VOICES - 1)) ? '0 : steal_ptr + SP_W'(1);
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        organ_voice #(
            .DIV_W (DIV_W),
            .AMP   (AMP)
        ) u_voice (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (v_load[g]),
            .retrig  (v_retrig[g]),
            .clear   (v_clear[g]),
            .note_in (note_q),
            .mode_in (mode_q),
            .div_in  (div_d),
            .active  (voice_active[g]),
            .note    (v_note[g]),
            .out_l   (v_l[g]),
            .out_r   (v_r[g])
        );
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum_l += v_l[i];
            sum_r += v_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            audio_left  <= sum_l;
            audio_right <= sum_r;
        end
    end

endmodule
